// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: a granted port keeps the grant for up to weight[i]
// acknowledged transfers while it keeps requesting. Optional macro ARBITER_WRR_CREDIT_OUT_EN adds credit_remaining.
module arbiter_wrr #(
    parameter int PORTS                 = 4,
    parameter int CL_PORTS              = (PORTS > 1) ? $clog2(PORTS) : 1,
    parameter int WEIGHT_WIDTH          = 4,
    parameter bit ARB_BLOCK_ACK         = 1'b1,
    parameter bit ARB_LSB_HIGH_PRIORITY = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORTS-1:0]                request,
    input  logic [PORTS-1:0]                acknowledge,
    input  logic [PORTS*WEIGHT_WIDTH-1:0]   weight,
    output logic [PORTS-1:0]                grant,
    output logic                            grant_valid,
`ifdef ARBITER_WRR_CREDIT_OUT_EN
    output logic [CL_PORTS-1:0]             grant_encoded,
    output logic [WEIGHT_WIDTH-1:0]         credit_remaining
`else
    output logic [CL_PORTS-1:0]             grant_encoded
`endif
);

    // Handshake: a requester holds request until served; grant is registered and
    // one-hot; acknowledge on the granted bit marks one completed transfer, other
    // acknowledge bits are ignored.

    logic [PORTS-1:0]        grant_reg, grant_next;
    logic                    grant_valid_reg, grant_valid_next;
    logic [CL_PORTS-1:0]     grant_encoded_reg, grant_encoded_next;
    logic [WEIGHT_WIDTH-1:0] credit_reg, credit_next;
    logic [PORTS-1:0]        mask_reg, mask_next;

    logic [PORTS-1:0]        masked_request;
    logic [CL_PORTS-1:0]     win_idx;
    logic [PORTS-1:0]        win_grant;
    logic [PORTS-1:0]        win_mask;
    logic [WEIGHT_WIDTH-1:0] win_weight;
    logic [WEIGHT_WIDTH-1:0] win_credit;
    logic                    ack_hit;
    logic                    req_hit;
    logic                    rearb;

    function automatic logic [CL_PORTS-1:0] pick(input logic [PORTS-1:0] v);
        logic [CL_PORTS-1:0] idx;
        idx = '0;
        if (ARB_LSB_HIGH_PRIORITY) begin
            for (int i = PORTS - 1; i >= 0; i--)
                if (v[i]) idx = CL_PORTS'(i);
        end else begin
            for (int i = 0; i < PORTS; i++)
                if (v[i]) idx = CL_PORTS'(i);
        end
        return idx;
    endfunction

    assign masked_request = request & mask_reg;
    assign win_idx        = (|masked_request) ? pick(masked_request) : pick(request);
    assign ack_hit        = |(grant_reg & acknowledge);
    assign req_hit        = |(grant_reg & request);

    // Winner decode: one-hot grant, its weight, and the round-robin mask that
    // excludes the winner and everything of higher priority than it.
    always_comb begin
        win_grant  = '0;
        win_mask   = '0;
        win_weight = '0;
        for (int i = 0; i < PORTS; i++) begin
            win_grant[i] = (i == int'(win_idx));
            win_mask[i]  = ARB_LSB_HIGH_PRIORITY ? (i > int'(win_idx)) : (i < int'(win_idx));
            if (i == int'(win_idx))
                win_weight = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
        win_credit = (win_weight == '0) ? WEIGHT_WIDTH'(1) : win_weight;
    end

    always_comb begin
        grant_next         = grant_reg;
        grant_valid_next   = grant_valid_reg;
        grant_encoded_next = grant_encoded_reg;
        credit_next        = credit_reg;
        mask_next          = mask_reg;
        rearb              = 1'b0;

        if (grant_valid_reg) begin
            if (ack_hit) begin
                if (credit_reg > WEIGHT_WIDTH'(1) && req_hit)
                    credit_next = credit_reg - WEIGHT_WIDTH'(1);
                else
                    rearb = 1'b1;
            end else if (!ARB_BLOCK_ACK && !req_hit) begin
                rearb = 1'b1;
            end
        end else begin
            rearb = 1'b1;
        end

        if (rearb) begin
            if (|request) begin
                grant_next         = win_grant;
                grant_valid_next   = 1'b1;
                grant_encoded_next = win_idx;
                credit_next        = win_credit;
                mask_next          = win_mask;
            end else begin
                // Idle: keep the mask so rotation resumes where it left off.
                grant_next         = '0;
                grant_valid_next   = 1'b0;
                grant_encoded_next = '0;
                credit_next        = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_reg         <= '0;
            grant_valid_reg   <= 1'b0;
            grant_encoded_reg <= '0;
            credit_reg        <= '0;
            mask_reg          <= '0;
        end else begin
            grant_reg         <= grant_next;
            grant_valid_reg   <= grant_valid_next;
            grant_encoded_reg <= grant_encoded_next;
            credit_reg        <= credit_next;
            mask_reg          <= mask_next;
        end
    end

    assign grant         = grant_reg;
    assign grant_valid   = grant_valid_reg;
    assign grant_encoded = grant_encoded_reg;

`ifdef ARBITER_WRR_CREDIT_OUT_EN
    assign credit_remaining = credit_reg;
`else
`endif

endmodule
